counter: RTL and testbench
==========================

COUNTER -- requirements
Module: counter

Interface
REQ-001 SHALL have parameter WIDTH, default 5, counter bit width (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port act, input, 1 bit: count enable; 1 = count on this edge, 0 = hold.
REQ-005 SHALL have port up_dwn_n, input, 1 bit: direction; 1 = increment, 0 = decrement.
REQ-006 SHALL have port count, output, WIDTH bits: current counter value, driven directly from a register.
REQ-007 SHALL have port ovflw, output, 1 bit: wrap indication, driven directly from a register.

Function
REQ-008 SHALL treat count as an unsigned modulo-2^WIDTH value.
REQ-009 Rising edge with rst=0, act=1, up_dwn_n=1: SHALL set count <= count+1.
REQ-010 Rising edge with rst=0, act=1, up_dwn_n=0: SHALL set count <= count-1.
REQ-011 Rising edge with rst=0, act=0: SHALL hold count unchanged, regardless of up_dwn_n.
REQ-012 Up wrap: when counting up from 2^WIDTH-1, SHALL load count=0 and set ovflw=1 on the same edge.
REQ-013 Down wrap: when counting down from 0, SHALL load count=2^WIDTH-1 and set ovflw=1 on the same edge.
REQ-014 ovflw (macro absent) SHALL be a one-cycle pulse, high only during the cycle in which count holds the wrapped value.
REQ-015 ovflw SHALL be 0 on every non-wrapping edge, including edges with act=0 (macro absent).
REQ-016 up_dwn_n SHALL be sampled every edge; a direction change SHALL take effect on the first edge where it is sampled, with no dead cycle.
REQ-017 Latency: SHALL show the effect of act/up_dwn_n sampled at an edge on count/ovflw immediately after that edge (1-edge latency).
REQ-018 SHALL contain no combinational path from inputs to outputs.

Reset
REQ-019 rst=1 at a rising edge SHALL force count=0 and ovflw=0, overriding act and up_dwn_n.
REQ-020 Reset asserted mid-count SHALL abort counting immediately; after deassertion, counting SHALL resume from 0 on the first edge with act=1.
REQ-021 Reset SHALL have no effect between clock edges (synchronous only).

Configuration
REQ-022 With macro COUNTER_STICKY_OVFLW_EN defined, ovflw SHALL be sticky: once set by a wrap, it SHALL stay 1 until an edge with rst=1.
REQ-023 With COUNTER_STICKY_OVFLW_EN defined, count behaviour SHALL be identical to the macro-absent behaviour.
REQ-024 Without COUNTER_STICKY_OVFLW_EN, ovflw SHALL follow REQ-014/REQ-015 (single-cycle pulse).

Verification
REQ-025 WIDTH=5, rst=1 for 10 edges with act=1 -> count=0 and ovflw=0 throughout.
REQ-026 Release reset, act=1, up_dwn_n=1 for 32 edges -> count 1..31, then 0 with ovflw=1 for exactly one cycle; next edge -> count=1, ovflw=0.
REQ-027 Count up to 17, assert rst=1 for 1 edge with act=1 -> count=0; deassert -> next edge count=1.
REQ-028 From 0, up 4 edges (count=4), then up_dwn_n=0 -> 3,2,1,0, then 31 with ovflw=1 for one cycle, then 30.
REQ-029 At count=9, act=0 for 5 edges with up_dwn_n toggling -> count stays 9, ovflw=0.
REQ-030 COUNTER_STICKY_OVFLW_EN defined, up-wrap from 31 -> ovflw=1 and stays 1 through 10 further edges; rst edge -> ovflw=0.

Source files
------------

// File: rtl/counter.sv
// Up/down modulo-2^WIDTH counter with a registered wrap flag.
// Define COUNTER_STICKY_OVFLW_EN to hold ovflw high after the first wrap until reset.
module counter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             act,
    input  logic             up_dwn_n,
    output logic [WIDTH-1:0] count,
    output logic             ovflw
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovflw_q, ovflw_d;
    logic             wrap;

    always_comb begin
        count_d = count_q;
        wrap    = 1'b0;
        if (act) begin
            if (up_dwn_n) begin
                count_d = count_q + ONE;
                wrap    = &count_q;
            end else begin
                count_d = count_q - ONE;
                wrap    = ~|count_q;
            end
        end
`ifdef COUNTER_STICKY_OVFLW_EN
        ovflw_d = ovflw_q | wrap;
`else
        ovflw_d = wrap;
`endif
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ovflw_q <= 1'b0;
        end else begin
            count_q <= count_d;
            ovflw_q <= ovflw_d;
        end
    end

    assign count = count_q;
    assign ovflw = ovflw_q;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed scenarios plus random traffic,
// compared against an integer-arithmetic model of the counting rules.
module tb_counter;

    localparam int WIDTH = 5;
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             act;
    logic             up_dwn_n;
    logic [WIDTH-1:0] count;
    logic             ovflw;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int model_count = 0;
    int model_ovflw = 0;

    counter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .act      (act),
        .up_dwn_n (up_dwn_n),
        .count    (count),
        .ovflw    (ovflw)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: next value by plain arithmetic, wrap when the result leaves 0..MOD-1.
    task automatic model_edge(input logic r, input logic a, input logic d);
        int nxt;
        int wrapped;
        wrapped = 0;
        if (r) begin
            model_count = 0;
            model_ovflw = 0;
        end else begin
            if (a) begin
                nxt = model_count + (d ? 1 : -1);
                wrapped = (nxt < 0 || nxt >= MOD) ? 1 : 0;
                model_count = (nxt + MOD) % MOD;
            end
`ifdef COUNTER_STICKY_OVFLW_EN
            model_ovflw = (model_ovflw != 0 || wrapped != 0) ? 1 : 0;
`else
            model_ovflw = wrapped;
`endif
        end
    endtask

    task automatic step(input logic r, input logic a, input logic d, input string tag);
        rst = r;
        act = a;
        up_dwn_n = d;
        @(posedge clk);
        model_edge(r, a, d);
        #1;
        chk({tag, "_count"}, int'(count), model_count);
        chk({tag, "_ovflw"}, int'(ovflw), model_ovflw);
    endtask

    initial begin
        rst = 1'b1;
        act = 1'b1;
        up_dwn_n = 1'b1;

        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b1, "reset_hold");
        chk("reset_count_zero", int'(count), 0);

        for (int i = 0; i < MOD - 1; i++) step(1'b0, 1'b1, 1'b1, "up_run");
        chk("up_reach_max", int'(count), MOD - 1);
        step(1'b0, 1'b1, 1'b1, "up_wrap");
        chk("up_wrap_count", int'(count), 0);
        chk("up_wrap_flag", int'(ovflw), 1);
        step(1'b0, 1'b1, 1'b1, "after_up_wrap");
        chk("after_up_wrap_count", int'(count), 1);

        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, "to_17");
        chk("at_17", int'(count), 17);
        step(1'b1, 1'b1, 1'b1, "mid_reset");
        chk("mid_reset_count", int'(count), 0);
        step(1'b0, 1'b1, 1'b1, "resume");
        chk("resume_count", int'(count), 1);

        step(1'b1, 1'b1, 1'b1, "reset_for_down");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, "up4");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, "down_to_0");
        chk("down_at_0", int'(count), 0);
        step(1'b0, 1'b1, 1'b0, "down_wrap");
        chk("down_wrap_count", int'(count), MOD - 1);
        chk("down_wrap_flag", int'(ovflw), 1);
        step(1'b0, 1'b1, 1'b0, "after_down_wrap");
        chk("after_down_wrap_count", int'(count), MOD - 2);

        step(1'b1, 1'b0, 1'b0, "reset_for_hold");
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b1, "to_9");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, logic'(i % 2), "hold");
        chk("hold_count", int'(count), 9);

        // Reset pulse entirely between edges must leave state untouched.
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        chk("async_glitch_count", int'(count), 9);

        step(1'b1, 1'b1, 1'b1, "reset_for_sticky");
        for (int i = 0; i < MOD; i++) step(1'b0, 1'b1, 1'b1, "sticky_wrap");
        for (int i = 0; i < 10; i++) step(1'b0, logic'(i % 3 != 0), 1'b1, "post_wrap");
        step(1'b1, 1'b0, 1'b0, "sticky_clear");
        chk("sticky_clear_flag", int'(ovflw), 0);

        for (int i = 0; i < 400; i++)
            step(logic'($urandom_range(0, 24) == 0), logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 1)), "random");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
